// File: rtl/rvh_l1d_mshr_sched.sv
// ============================================================================
// Module   : rvh_l1d_mshr_sched
// Purpose  : L1D MSHR allocator: round-robin miss-requester grant, lowest-free
//            entry pick, release tracking. Option: RVH_L1D_MSHR_SCHED_RESERVE_EN
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rvh_l1d_mshr_sched #(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned N_MSHR  = 4,
    parameter int unsigned ID_W    = (N_MSHR > 1) ? $clog2(N_MSHR) : 1,
    localparam int unsigned C_REQ_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_vld_i,
    output logic [N_REQ-1:0]   req_rdy_o,
    output logic               alloc_vld_o,
    output logic [ID_W-1:0]    alloc_id_o,
    output logic [C_REQ_W-1:0] alloc_req_o,
    input  logic               dealloc_vld_i,
    input  logic [ID_W-1:0]    dealloc_id_i,
    output logic [N_MSHR-1:0]  mshr_vld_o,
    output logic [ID_W:0]      free_num_o,
    output logic               full_o,
    output logic               dealloc_err_o
);

    logic [N_MSHR-1:0]  mshr_vld_q, mshr_vld_d;
    logic [C_REQ_W-1:0] rr_ptr_q, rr_ptr_d;
    logic               dealloc_err_q, dealloc_err_d;

    logic [N_MSHR-1:0]  w_free;
    logic [ID_W:0]      w_free_num;
    logic [ID_W-1:0]    w_low_id;
    logic [N_REQ-1:0]   w_elig;
    logic [C_REQ_W:0]   w_idx;
    logic               w_grant_found;
    logic [C_REQ_W-1:0] w_grant_idx;
    logic               w_fire;
    logic               w_dealloc_hit;

    always_comb begin
        w_free     = ~mshr_vld_q;
        w_free_num = '0;
        w_low_id   = '0;
        for (int i = N_MSHR - 1; i >= 0; i--) begin
            if (w_free[i]) w_low_id = ID_W'(i);
        end
        for (int i = 0; i < N_MSHR; i++) begin
            w_free_num = w_free_num + (ID_W + 1)'(w_free[i]);
        end
    end

`ifdef RVH_L1D_MSHR_SCHED_RESERVE_EN
    // The last free entry is kept back for requester 0.
    always_comb begin
        w_elig    = {N_REQ{w_free_num >= (ID_W + 1)'(2)}};
        w_elig[0] = (w_free_num != '0);
    end
`else
    assign w_elig = {N_REQ{w_free_num != '0}};
`endif

    // Round-robin search from rr_ptr_q; ineligible requesters are skipped.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_idx         = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = {1'b0, rr_ptr_q} + (C_REQ_W + 1)'(k);
            if (w_idx >= (C_REQ_W + 1)'(N_REQ)) w_idx = w_idx - (C_REQ_W + 1)'(N_REQ);
            if (!w_grant_found && req_vld_i[w_idx[C_REQ_W-1:0]] && w_elig[w_idx[C_REQ_W-1:0]]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_idx[C_REQ_W-1:0];
            end
        end
    end

    assign w_fire = rst & w_grant_found;

    always_comb begin
        req_rdy_o = '0;
        if (w_fire) req_rdy_o[w_grant_idx] = 1'b1;
    end

    always_comb begin
        mshr_vld_d    = mshr_vld_q;
        w_dealloc_hit = 1'b0;
        // Out-of-range ids never match, so they fall through to the error pulse.
        for (int i = 0; i < N_MSHR; i++) begin
            if (dealloc_vld_i && (dealloc_id_i == ID_W'(i)) && mshr_vld_q[i]) begin
                mshr_vld_d[i] = 1'b0;
                w_dealloc_hit = 1'b1;
            end
        end
        if (w_fire) mshr_vld_d[w_low_id] = 1'b1;
        dealloc_err_d = dealloc_vld_i & ~w_dealloc_hit;

        rr_ptr_d = rr_ptr_q;
        if (w_fire) begin
            if (w_grant_idx == C_REQ_W'(N_REQ - 1)) rr_ptr_d = '0;
            else                                     rr_ptr_d = w_grant_idx + C_REQ_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mshr_vld_q    <= '0;
            rr_ptr_q      <= '0;
            dealloc_err_q <= 1'b0;
        end else begin
            mshr_vld_q    <= mshr_vld_d;
            rr_ptr_q      <= rr_ptr_d;
            dealloc_err_q <= dealloc_err_d;
        end
    end

    assign alloc_vld_o   = w_fire;
    assign alloc_id_o    = w_low_id;
    assign alloc_req_o   = w_grant_idx;
    assign mshr_vld_o    = mshr_vld_q;
    assign free_num_o    = w_free_num;
    assign full_o        = (w_free_num == '0);
    assign dealloc_err_o = dealloc_err_q;

endmodule

`default_nettype wire

// File: tb/tb_rvh_l1d_mshr_sched.sv
// ============================================================================
// Module   : tb_rvh_l1d_mshr_sched
// Purpose  : Directed plus random checks of rvh_l1d_mshr_sched against a model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rvh_l1d_mshr_sched;
    localparam int N_REQ  = 2;
    localparam int N_MSHR = 4;
    localparam int ID_W   = 2;

    logic              clk;
    logic              rst;
    logic [N_REQ-1:0]  req_vld_i;
    logic [N_REQ-1:0]  req_rdy_o;
    logic              alloc_vld_o;
    logic [ID_W-1:0]   alloc_id_o;
    logic [0:0]        alloc_req_o;
    logic              dealloc_vld_i;
    logic [ID_W-1:0]   dealloc_id_i;
    logic [N_MSHR-1:0] mshr_vld_o;
    logic [ID_W:0]     free_num_o;
    logic              full_o;
    logic              dealloc_err_o;

    rvh_l1d_mshr_sched #(.N_REQ(N_REQ), .N_MSHR(N_MSHR)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .req_vld_i     (req_vld_i),
        .req_rdy_o     (req_rdy_o),
        .alloc_vld_o   (alloc_vld_o),
        .alloc_id_o    (alloc_id_o),
        .alloc_req_o   (alloc_req_o),
        .dealloc_vld_i (dealloc_vld_i),
        .dealloc_id_i  (dealloc_id_i),
        .mshr_vld_o    (mshr_vld_o),
        .free_num_o    (free_num_o),
        .full_o        (full_o),
        .dealloc_err_o (dealloc_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: which entries are busy, where round-robin starts.
    bit m_busy [N_MSHR];
    int m_rr  = 0;
    bit m_err = 0;

    // DUT grant outputs captured by the last step, for directed checks.
    logic              g_vld;
    logic [ID_W-1:0]   g_id;
    logic              g_req;
    logic [N_REQ-1:0]  g_rdy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [N_REQ-1:0] req, input logic dv,
                        input logic [ID_W-1:0] did, input logic rst_v);
        int  nfree, low, gidx;
        bit  fire, el;
        logic [N_MSHR-1:0] vec;
        @(negedge clk);
        rst           = rst_v;
        req_vld_i     = req;
        dealloc_vld_i = dv;
        dealloc_id_i  = did;
        #1;
        nfree = 0; low = -1;
        for (int i = 0; i < N_MSHR; i++) begin
            if (!m_busy[i]) begin
                nfree++;
                if (low < 0) low = i;
            end
        end
        fire = 0; gidx = 0;
        if (rst_v) begin
            for (int k = 0; k < N_REQ; k++) begin
                int r;
                r = (m_rr + k) % N_REQ;
`ifdef RVH_L1D_MSHR_SCHED_RESERVE_EN
                el = (r == 0) ? (nfree >= 1) : (nfree >= 2);
`else
                el = (nfree >= 1);
`endif
                if (!fire && req[r] && el) begin
                    fire = 1;
                    gidx = r;
                end
            end
        end
        chk("alloc_vld", 32'(alloc_vld_o), 32'(fire));
        chk("req_rdy", 32'(req_rdy_o), fire ? (32'd1 << gidx) : 32'd0);
        if (fire) begin
            chk("alloc_id", 32'(alloc_id_o), 32'(low));
            chk("alloc_req", 32'(alloc_req_o), 32'(gidx));
        end
        g_vld = alloc_vld_o; g_id = alloc_id_o; g_req = alloc_req_o; g_rdy = req_rdy_o;

        @(posedge clk);
        if (!rst_v) begin
            for (int i = 0; i < N_MSHR; i++) m_busy[i] = 0;
            m_rr = 0; m_err = 0;
        end else begin
            bit legal;
            legal = dv && (int'(did) < N_MSHR) && m_busy[did];
            m_err = dv && !legal;
            if (legal) m_busy[did] = 0;
            if (fire) begin
                m_busy[low] = 1;
                m_rr = (gidx + 1) % N_REQ;
            end
        end
        #1;
        vec = '0; nfree = 0;
        for (int i = 0; i < N_MSHR; i++) begin
            vec[i] = m_busy[i];
            if (!m_busy[i]) nfree++;
        end
        chk("mshr_vld", 32'(mshr_vld_o), 32'(vec));
        chk("free_num", 32'(free_num_o), 32'(nfree));
        chk("full", 32'(full_o), 32'(nfree == 0));
        chk("dealloc_err", 32'(dealloc_err_o), 32'(m_err));
    endtask

    initial begin
        logic [N_REQ-1:0] pend;
        rst = 1'b0; req_vld_i = '0; dealloc_vld_i = 1'b0; dealloc_id_i = '0;

        // Requests during reset must not be granted.
        step(2'b11, 1'b0, 2'd0, 1'b0);
        step(2'b11, 1'b1, 2'd1, 1'b0);

        // Single requester fills entries in index order, then stalls.
        for (int k = 0; k < 4; k++) begin
            step(2'b01, 1'b0, 2'd0, 1'b1);
            chk("fill_id", 32'(g_id), 32'(k));
        end
        step(2'b01, 1'b0, 2'd0, 1'b1);
        chk("full_rdy", 32'(g_rdy), 32'd0);

        // Released entry becomes grantable only the following cycle.
        step(2'b01, 1'b1, 2'd2, 1'b1);
        chk("dealloc_cycle_vld", 32'(g_vld), 32'd0);
        step(2'b01, 1'b0, 2'd0, 1'b1);
        chk("after_dealloc_vld", 32'(g_vld), 32'd1);
        chk("after_dealloc_id", 32'(g_id), 32'd2);

        // Release of a free entry leaves state alone and flags an error.
        step(2'b00, 1'b0, 2'd0, 1'b0);
        step(2'b01, 1'b0, 2'd0, 1'b1);
        step(2'b00, 1'b1, 2'd3, 1'b1);
        chk("bad_dealloc_err", 32'(dealloc_err_o), 32'd1);
        chk("bad_dealloc_vec", 32'(mshr_vld_o), 32'b0001);
        step(2'b00, 1'b0, 2'd0, 1'b1);
        chk("err_one_cycle", 32'(dealloc_err_o), 32'd0);

        // Simultaneous alloc and release of different entries.
        step(2'b01, 1'b0, 2'd0, 1'b1);
        step(2'b10, 1'b1, 2'd0, 1'b1);
        chk("same_cycle_vec", 32'(mshr_vld_o), 32'b0110);

        step(2'b00, 1'b0, 2'd0, 1'b0);
`ifdef RVH_L1D_MSHR_SCHED_RESERVE_EN
        for (int k = 0; k < 3; k++) step(2'b01, 1'b0, 2'd0, 1'b1);
        step(2'b10, 1'b0, 2'd0, 1'b1);
        chk("reserve_block", 32'(g_vld), 32'd0);
        step(2'b11, 1'b0, 2'd0, 1'b1);
        chk("reserve_req", 32'(g_req), 32'd0);
        chk("reserve_id", 32'(g_id), 32'd3);
`else
        for (int k = 0; k < 4; k++) begin
            step(2'b11, 1'b0, 2'd0, 1'b1);
            chk("rr_req", 32'(g_req), 32'(k % 2));
            chk("rr_id", 32'(g_id), 32'(k));
        end
`endif

        // Random traffic; requests held until granted, occasional reset.
        pend = '0;
        for (int c = 0; c < 3000; c++) begin
            logic rv;
            pend = pend | N_REQ'($urandom);
            rv   = ($urandom_range(63) != 0);
            step(pend, ($urandom_range(9) < 4), ID_W'($urandom), rv);
            pend = pend & ~g_rdy;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
